// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential 16-by-8 restoring divider.
//   DIV_N      : divisor / quotient / remainder width (dividend is 2*DIV_N)
//   DIV_CNT_W  : width of the iteration counter (counts DIV_N-1 down to 0)
//   div_state_t: controller states
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_N     = 8;
    localparam int DIV_CNT_W = $clog2(DIV_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational iteration of restoring division on the {R,Q} pair.
//   r_in    [N-1:0] : partial remainder (always < divisor between steps)
//   q_in    [N-1:0] : dividend low bits being shifted out / quotient shifted in
//   divisor [N-1:0] : divisor
//   r_out   [N-1:0] : partial remainder after this step
//   q_out   [N-1:0] : Q shifted left with the new quotient bit in bit 0
// ----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N-1:0] r_in,
    input  logic [N-1:0] q_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] r_out,
    output logic [N-1:0] q_out
);

    logic [N:0] r_shift;
    logic [N:0] trial;

    // The shifted remainder is below 2*divisor, so the N+1-bit difference has
    // its top bit clear exactly when the subtraction did not go negative.
    // A restored remainder is below the divisor, so its top bit is zero and
    // only the low N bits need to be kept.
    always_comb begin
        r_shift = {r_in, q_in[N-1]};
        trial   = r_shift - {1'b0, divisor};
        if (!trial[N]) begin
            r_out = trial[N-1:0];
            q_out = {q_in[N-2:0], 1'b1};
        end else begin
            r_out = r_shift[N-1:0];
            q_out = {q_in[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_16x8_seq.sv
// ----------------------------------------------------------------------------
// div_16x8_seq
// Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, one operation in flight.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   dividend [2N-1:0]     : unsigned dividend
//   divisor  [N-1:0]      : unsigned divisor
//   out_valid / out_ready : result handshake (valid only in DONE)
//   quotient, remainder   : registered results, held through DONE
//   div_by_zero           : divisor was zero
//   overflow              : true quotient would not fit in N bits
// CNT_W must be wide enough to hold N-1.
// ----------------------------------------------------------------------------
module div_16x8_seq
    import div_pkg::*;
#(
    parameter int N     = DIV_N,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    div_state_t       state;
    div_state_t       next_state;
    logic [N-1:0]     r_reg;
    logic [N-1:0]     q_reg;
    logic [N-1:0]     dvs_reg;
    logic [CNT_W-1:0] cnt;
    logic             dbz_reg;
    logic             ovf_reg;
    logic [N-1:0]     r_next;
    logic [N-1:0]     q_next;
    logic             accept;
    logic             is_zero;
    logic             is_ovf;

    // The divisor is latched at accept so the operand bus is free while busy.
    div_step #(.N(N)) u_step (
        .r_in    (r_reg),
        .q_in    (q_reg),
        .divisor (dvs_reg),
        .r_out   (r_next),
        .q_out   (q_next)
    );

    // Zero divisor and quotients too large for N bits skip the iteration
    // loop entirely and report saturated results one edge after accept.
    always_comb begin
        accept  = in_valid && (state == IDLE);
        is_zero = (divisor == '0);
        is_ovf  = !is_zero && (dividend[2*N-1:N] >= divisor);
    end

    // Next-state decode; DONE waits for the consumer and does not look at
    // in_valid, so a result can never be taken and replaced on the same edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (is_zero || is_ovf) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and datapath registers. The remainder register is kept N bits
    // wide because a restored remainder never reaches the divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r_reg   <= '0;
            q_reg   <= '0;
            dvs_reg <= '0;
            cnt     <= '0;
            dbz_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvs_reg <= divisor;
                        if (is_zero) begin
                            q_reg   <= '1;
                            r_reg   <= dividend[N-1:0];
                            dbz_reg <= 1'b1;
                            ovf_reg <= 1'b0;
                        end else if (is_ovf) begin
                            q_reg   <= '1;
                            r_reg   <= '0;
                            dbz_reg <= 1'b0;
                            ovf_reg <= 1'b1;
                        end else begin
                            r_reg   <= dividend[2*N-1:N];
                            q_reg   <= dividend[N-1:0];
                            cnt     <= CNT_W'(N-1);
                            dbz_reg <= 1'b0;
                            ovf_reg <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = q_reg;
    assign remainder   = r_reg;
    assign div_by_zero = dbz_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_div_16x8_seq.sv
// ----------------------------------------------------------------------------
// tb_div_16x8_seq
// Self-checking bench for div_16x8_seq: directed vector table, backpressure,
// reset during BUSY, random non-overflow pairs and product round-trips.
// Latency is counted in edges after the accepting edge until out_valid is
// seen: N for the iterative path, 0 for the saturating paths (result is
// already visible right after the accepting edge).
// ----------------------------------------------------------------------------
module tb_div_16x8_seq;
    import div_pkg::*;

    localparam int N = DIV_N;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    div_16x8_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one operation, wait for it to be accepted, then count edges
    // until the result appears (bounded).
    task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 20) begin
            check("in_ready_timeout", 32'(guard), 32'd0);
        end
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] q, input logic [7:0] r,
                               input logic dbz, input logic ovf, input int explat, input int lat);
        check({name, ".out_valid"}, 32'(out_valid), 32'd1);
        check({name, ".quotient"}, 32'(quotient), 32'(q));
        check({name, ".remainder"}, 32'(remainder), 32'(r));
        check({name, ".div_by_zero"}, 32'(div_by_zero), 32'(dbz));
        check({name, ".overflow"}, 32'(overflow), 32'(ovf));
        check({name, ".latency"}, 32'(lat), 32'(explat));
    endtask

    // With out_ready high, the edge after the result appears returns to IDLE.
    task automatic checkRelease(input string name);
        @(posedge clk);
        #1;
        check({name, ".released_valid"}, 32'(out_valid), 32'd0);
        check({name, ".released_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int a;
        int b;
        int p;
        logic stray;

        vecs[0]  = '{16'h03E8, 8'h07, 8'd142, 8'd6,   1'b0, 1'b0, N};
        vecs[1]  = '{16'hFE01, 8'hFF, 8'd255, 8'd0,   1'b0, 1'b0, N};
        vecs[2]  = '{16'h0100, 8'h01, 8'hFF,  8'h00,  1'b0, 1'b1, 0};
        vecs[3]  = '{16'h1234, 8'h00, 8'hFF,  8'h34,  1'b1, 1'b0, 0};
        vecs[4]  = '{16'd100,  8'd10, 8'd10,  8'd0,   1'b0, 1'b0, N};
        vecs[5]  = '{16'h00FF, 8'h01, 8'd255, 8'd0,   1'b0, 1'b0, N};
        vecs[6]  = '{16'h7FFF, 8'h80, 8'd255, 8'd127, 1'b0, 1'b0, N};
        vecs[7]  = '{16'h0000, 8'h05, 8'd0,   8'd0,   1'b0, 1'b0, N};
        vecs[8]  = '{16'h0004, 8'h05, 8'd0,   8'd4,   1'b0, 1'b0, N};
        vecs[9]  = '{16'hFFFF, 8'hFF, 8'hFF,  8'h00,  1'b0, 1'b1, 0};
        vecs[10] = '{16'hFEFF, 8'hFF, 8'd255, 8'd254, 1'b0, 1'b0, N};
        vecs[11] = '{16'h0000, 8'h00, 8'hFF,  8'h00,  1'b1, 1'b0, 0};
        vecs[12] = '{16'h1234, 8'h12, 8'hFF,  8'h00,  1'b0, 1'b1, 0};
        vecs[13] = '{16'h1234, 8'h13, 8'd245, 8'd5,   1'b0, 1'b0, N};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.quotient", 32'(quotient), 32'd0);
        check("reset.remainder", 32'(remainder), 32'd0);
        check("reset.div_by_zero", 32'(div_by_zero), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        $display("[TB] directed vector table");
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs, lat);
            checkOutput($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf,
                        vecs[i].lat, lat);
            checkRelease($sformatf("vec%0d", i));
        end

        $display("[TB] backpressure in DONE");
        out_ready = 1'b0;
        applyStimulus(16'h03E8, 8'h07, lat);
        checkOutput("bp", 8'd142, 8'd6, 1'b0, 1'b0, N, lat);
        in_valid = 1'b1;
        dividend = 16'h0100;
        divisor  = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp.hold%0d.out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp.hold%0d.in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp.hold%0d.quotient", i), 32'(quotient), 32'd142);
            check($sformatf("bp.hold%0d.remainder", i), 32'(remainder), 32'd6);
            check($sformatf("bp.hold%0d.overflow", i), 32'(overflow), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkRelease("bp");
        applyStimulus(16'd100, 8'd10, lat);
        checkOutput("bp.next", 8'd10, 8'd0, 1'b0, 1'b0, N, lat);
        checkRelease("bp.next");

        $display("[TB] reset during BUSY");
        in_valid = 1'b1;
        dividend = 16'h03E8;
        divisor  = 8'h07;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.quotient", 32'(quotient), 32'd0);
        check("midrst.remainder", 32'(remainder), 32'd0);
        check("midrst.div_by_zero", 32'(div_by_zero), 32'd0);
        check("midrst.overflow", 32'(overflow), 32'd0);
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray = 1'b1;
        end
        check("midrst.no_stray_result", 32'(stray), 32'd0);
        applyStimulus(16'd100, 8'd10, lat);
        checkOutput("midrst.next", 8'd10, 8'd0, 1'b0, 1'b0, N, lat);
        checkRelease("midrst.next");

        $display("[TB] random non-overflow pairs");
        for (int i = 0; i < 300; i++) begin
            b = int'($urandom_range(1, 255));
            a = int'($urandom_range(0, b * 256 - 1));
            applyStimulus(16'(a), 8'(b), lat);
            checkOutput($sformatf("rnd%0d(%0d/%0d)", i, a, b), 8'(a / b), 8'(a % b),
                        1'b0, 1'b0, N, lat);
            checkRelease($sformatf("rnd%0d", i));
        end

        $display("[TB] product round-trips");
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            p = a * b;
            applyStimulus(16'(p), 8'(b), lat);
            checkOutput($sformatf("prod%0d(%0d*%0d)", i, a, b), 8'(a), 8'd0,
                        1'b0, 1'b0, N, lat);
            checkRelease($sformatf("prod%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
